// File: rtl/fcmple_core.sv
// Single-precision "A <= B" comparator for the branch unit. Denormals flush to zero.
// Result bit 0 carries the outcome. LATENCY=0 is combinational and LATENCY=1 adds one output register.
module fcmple_core #(
  parameter int unsigned LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_a_tdata,
  input  logic [31:0] s_axis_b_tdata,
  output logic [7:0]  m_axis_result_tdata
);

  logic        a_nan, b_nan;
  logic        a_zero, b_zero;
  logic        a_neg, b_neg;
  logic [30:0] a_mag, b_mag;
  logic        le;
  logic [7:0]  result_d, result_q;

  always_comb begin
    a_nan  = (s_axis_a_tdata[30:23] == 8'hFF) && (s_axis_a_tdata[22:0] != 23'd0);
    b_nan  = (s_axis_b_tdata[30:23] == 8'hFF) && (s_axis_b_tdata[22:0] != 23'd0);
    a_zero = (s_axis_a_tdata[30:23] == 8'h00);
    b_zero = (s_axis_b_tdata[30:23] == 8'h00);
    // Flushed zeros count as positive with zero magnitude, whatever their sign bit.
    a_neg  = s_axis_a_tdata[31] & ~a_zero;
    b_neg  = s_axis_b_tdata[31] & ~b_zero;
    a_mag  = a_zero ? 31'd0 : s_axis_a_tdata[30:0];
    b_mag  = b_zero ? 31'd0 : s_axis_b_tdata[30:0];
  end

  always_comb begin
    le = 1'b0;
    if (a_nan || b_nan) begin
      le = 1'b0;
    end else if (a_zero && b_zero) begin
      le = 1'b1;
    end else if (a_neg && !b_neg) begin
      le = 1'b1;
    end else if (!a_neg && b_neg) begin
      le = 1'b0;
    end else if (!a_neg) begin
      le = (a_mag <= b_mag);
    end else begin
      le = (a_mag >= b_mag);
    end
    result_d = {7'd0, le};
  end

  // The register always exists. With LATENCY=0 it simply has no load, and synthesis removes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 8'h00;
    end else begin
      result_q <= result_d;
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign m_axis_result_tdata = result_d;
    end else begin : g_reg
      assign m_axis_result_tdata = result_q;
    end
  endgenerate

endmodule

// File: tb/tb_fcmple_core.sv
// Bench for fcmple_core that drives a combinational and a registered instance from the same inputs.
// Expected values come from directed constants and from a real-valued reference model.
module tb_fcmple_core;

  logic        clk;
  logic        reset;
  logic [31:0] a, b;
  logic [7:0]  res0, res1;
  int          total;
  int          bad;

  fcmple_core #(.LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .s_axis_a_tdata(a), .s_axis_b_tdata(b),
    .m_axis_result_tdata(res0)
  );

  fcmple_core #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .s_axis_a_tdata(a), .s_axis_b_tdata(b),
    .m_axis_result_tdata(res1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Numeric value of a binary32 operand. Denormals become 0. Infinity becomes a huge sentinel.
  function automatic real to_real(input logic [31:0] x);
    int  e;
    real v;
    e = int'(x[30:23]);
    if (e == 0)        v = 0.0;
    else if (e == 255) v = 1.0e300;
    else               v = (1.0 + $itor(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return x[31] ? -v : v;
  endfunction

  function automatic logic [7:0] model(input logic [31:0] x, input logic [31:0] y);
    logic xn, yn;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    if (xn || yn) return 8'h00;
    return (to_real(x) <= to_real(y)) ? 8'h01 : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s a=%h b=%h observed=%h expected=%h", tag, a, b, obs, exp);
    end
  endtask

  // Drive away from the sampling edge. Check the combinational output first, then the registered one.
  task automatic apply(input logic [31:0] av, input logic [31:0] bv,
                       input logic [7:0] exp, input string tag);
    @(negedge clk);
    a = av;
    b = bv;
    #1 check({tag, "_comb"}, res0, exp);
    @(posedge clk);
    #1 check({tag, "_reg"}, res1, exp);
  endtask

  logic [31:0] dir_a [17] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'hC0000000,
                             32'hBF800000, 32'hBF800000, 32'h3F800000, 32'h80000000,
                             32'h00000000, 32'h00000001, 32'h00000001, 32'h7F800000,
                             32'hFF800000, 32'h7F800000, 32'h7FC00000, 32'h3F800000,
                             32'h7FC00000};
  logic [31:0] dir_b [17] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                             32'hC0000000, 32'h3F800000, 32'hBF800000, 32'h00000000,
                             32'h80000000, 32'h80000000, 32'hBF800000, 32'h7F800000,
                             32'h3F800000, 32'h7F7FFFFF, 32'h3F800000, 32'hFFC00001,
                             32'h7FC00000};
  logic [7:0]  dir_e [17] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01,
                             8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00,
                             8'h00};

  initial begin
    logic [31:0] ra, rb;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    a     = 32'h3F800000;
    b     = 32'h40000000;

    // Reset is held for one edge. The registered output must be cleared, and the combinational output ignores reset.
    @(posedge clk);
    #1 check("reset_reg", res1, 8'h00);
    check("reset_comb", res0, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 check("first_sample", res1, 8'h01);

    for (int i = 0; i < 17; i++) begin
      apply(dir_a[i], dir_b[i], dir_e[i], $sformatf("dir%0d", i));
    end

    // Assert reset while 1.0 <= 2.0 is held. The next edge must load 0.
    apply(32'h3F800000, 32'h40000000, 8'h01, "pre_reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("reset_priority", res1, 8'h00);
    check("reset_comb_hold", res0, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 check("post_reset", res1, 8'h01);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: ;
        1: begin ra[30:23] = 8'h00; rb[30:23] = ($urandom_range(0, 1) != 0) ? 8'h00 : rb[30:23]; end
        2: begin ra[30:23] = 8'hFF; if ($urandom_range(0, 1) != 0) ra[22:0] = 23'd0; end
        3: rb = ra ^ {31'd0, 1'($urandom_range(0, 1))};
        default: rb = {~ra[31], ra[30:0]};
      endcase
      apply(ra, rb, model(ra, rb), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fcmple_core.md
Name: fcmple_core

Overview:
- Single-precision IEEE-754 "less than or equal" comparator used by the branch unit to resolve FLE-type conditional branches.
- Takes two 32-bit float operands and returns an 8-bit result word; bit 0 is the comparison outcome.
- Default configuration is zero-latency combinational, so the branch unit can evaluate its head compare entry in the same cycle.

Parameters:
- LATENCY, 0, pipeline depth in cycles. 0 = purely combinational output; 1 = output registered once on clk.

Ports:
- clk  input  1  clock; used only when LATENCY=1.
- reset  input  1  synchronous, active-high reset; clears the output register when LATENCY=1.
- s_axis_a_tdata  input  32  operand A, IEEE-754 binary32.
- s_axis_b_tdata  input  32  operand B, IEEE-754 binary32.
- m_axis_result_tdata  output  8  bit 0 = (A <= B); bits 7:1 always 0.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Field decode per operand: sign = bit 31, exponent = bits 30:23, mantissa = bits 22:0.
- Operand classes:
  - NaN: exponent = 0xFF and mantissa != 0.
  - Infinity: exponent = 0xFF and mantissa = 0.
  - Zero: exponent = 0x00, regardless of mantissa. Denormals are flushed to zero and their sign is ignored, consistent with the rest of the core, where exponent==0 means zero.
- Result bit 0 is computed in this priority order:
  1. Either operand is NaN -> 0 (unordered). Signalling and quiet NaNs are treated the same; no exception flags.
  2. Both operands are zero (including ±0 and denormals) -> 1.
  3. A negative, B positive (after zero handling: a zero operand counts as positive) -> 1.
  4. A positive, B negative -> 0.
  5. Both positive -> 1 iff unsigned bits[30:0] of A <= bits[30:0] of B.
  6. Both negative -> 1 iff bits[30:0] of A >= bits[30:0] of B.
- Rule 5 and 6 ordering is valid because exponent and mantissa are concatenated as a magnitude, which holds for normals and infinities. A flushed-zero operand uses magnitude 0 and counts as positive.
- Bits 7:1 of m_axis_result_tdata are always 0.
- LATENCY=0:
  - Output is a pure function of the current inputs, settling within the same cycle.
  - No state; clk and reset have no effect.
- LATENCY=1:
  - The result is registered on the rising edge of clk and appears one cycle after the inputs.
  - While reset is high at a clock edge, the register loads 0x00. Reset has priority over a new input sample.
  - The output is 0x00 from the first cycle after reset until the first sampled inputs.
- No handshake: the block accepts new operands every cycle; there are no valid or ready signals, and it never stalls.
- The output must never be X for any 32-bit input pattern.

Test Plan:
- Ordinary values: A=0x3F800000 (1.0), B=0x40000000 (2.0) -> 0x01. Swapped -> 0x00. A=B=0x3F800000 -> 0x01.
- Negatives: A=0xC0000000 (-2.0), B=0xBF800000 (-1.0) -> 0x01. Swapped -> 0x00. A=0xBF800000, B=0x3F800000 -> 0x01; reversed -> 0x00.
- Zeros and denormals: A=0x80000000 (-0), B=0x00000000 -> 0x01, and swapped -> 0x01. A=0x00000001 (denormal), B=0x80000000 -> 0x01. A=0x00000001, B=0xBF800000 -> 0x00.
- Infinities: A=0x7F800000 (+inf), B=0x7F800000 -> 0x01. A=0xFF800000, B=0x3F800000 -> 0x01. A=0x7F800000, B=0x7F7FFFFF -> 0x00.
- NaN: A=0x7FC00000 with B=0x3F800000 -> 0x00. A=0x3F800000 with B=0xFFC00001 -> 0x00. A=B=0x7FC00000 -> 0x00.
- LATENCY=1 timing:
  - Hold reset one cycle -> output 0x00.
  - Apply 1.0 <= 2.0 -> 0x01 exactly one cycle later.
  - Assert reset while inputs are held -> 0x00 on the next edge.
